// File: rtl/qam_pkg.sv
// Shared definitions for the 4-QAM modulator/demodulator pair: symbol bit
// mapping, default sample width and symbol length, and the demodulator state encoding.
package qam_pkg;

  localparam int SYM_I_BIT = 1;
  localparam int SYM_Q_BIT = 0;

  localparam int DEF_DW  = 16;
  localparam int DEF_SPS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INTEG  = 2'd1,
    DECIDE = 2'd2
  } qam_state_e;

endpackage

// File: rtl/qam_mac_branch.sv
// One signed multiply-accumulate branch of the demodulator. Load takes priority
// over accumulate, and accumulate takes priority over clear.
module qam_mac_branch #(
  parameter int DW = 16,
  parameter int AW = 2*DW+8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 accum_i,
  input  logic                 clr_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [AW-1:0] acc_o
);

  logic signed [2*DW-1:0] a_ext, b_ext, prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   acc_d, acc_q;

  // Widen before multiplying so the full DW x DW product is kept.
  assign a_ext    = {{DW{a_i[DW-1]}}, a_i};
  assign b_ext    = {{DW{b_i[DW-1]}}, b_i};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (load_i)       acc_d = prod_ext;
    else if (accum_i) acc_d = acc_q + prod_ext;
    else if (clr_i)   acc_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/qam_demodulator.sv
// Coherent 4-QAM demodulator: integrate-and-dump on I/Q, hard decision, 2-bit serializer.
// Optional soft outputs soft_i/soft_q are enabled with `define QAM_DEMOD_SOFT_EN.
module qam_demodulator
  import qam_pkg::*;
#(
  parameter int SPS = DEF_SPS,
  parameter int DW  = DEF_DW,
  parameter int AW  = 2*DW+8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic                 sym_sync,
  input  logic signed [DW-1:0] mixed_signal,
  input  logic signed [DW-1:0] ref_sine,
  input  logic signed [DW-1:0] ref_cosine,
  output logic [1:0]           parallel,
  output logic                 parallel_valid,
  output logic                 serial_bit,
  output logic                 serial_valid,
  output logic                 locked,
  output logic                 slip
`ifdef QAM_DEMOD_SOFT_EN
  ,
  output logic signed [AW-1:0] soft_i,
  output logic signed [AW-1:0] soft_q
`endif
);

  localparam int             CW   = $clog2(SPS+1);
  localparam logic [CW-1:0]  LAST = CW'(SPS-1);

  qam_state_e          state_q;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          parallel_q;
  logic                parallel_valid_q;
  logic                serial_bit_q, serial_valid_q;
  logic                pend_q, pend_bit_q;
  logic                locked_q, slip_q;
  logic                mac_load, mac_accum, mac_clr;
  logic signed [AW-1:0] acc_i, acc_q;
  logic                dec_i, dec_q;

  always_comb begin
    mac_load  = 1'b0;
    mac_accum = 1'b0;
    mac_clr   = 1'b0;
    case (state_q)
      IDLE:   mac_load = sample_valid && sym_sync;
      INTEG: begin
        mac_load  = sample_valid && sym_sync;
        mac_accum = sample_valid && !sym_sync;
      end
      DECIDE: begin
        mac_clr  = 1'b1;
        mac_load = sample_valid;
      end
      default: ;
    endcase
  end

  qam_mac_branch #(.DW(DW), .AW(AW)) u_mac_i (
    .clk_i(clk), .rst_i(rst), .load_i(mac_load), .accum_i(mac_accum), .clr_i(mac_clr),
    .a_i(mixed_signal), .b_i(ref_cosine), .acc_o(acc_i)
  );

  qam_mac_branch #(.DW(DW), .AW(AW)) u_mac_q (
    .clk_i(clk), .rst_i(rst), .load_i(mac_load), .accum_i(mac_accum), .clr_i(mac_clr),
    .a_i(mixed_signal), .b_i(ref_sine), .acc_o(acc_q)
  );

  // Strictly positive sum decides 1; zero and negative decide 0.
  assign dec_i = !acc_i[AW-1] && (acc_i != '0);
  assign dec_q = !acc_q[AW-1] && (acc_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      parallel_q       <= '0;
      parallel_valid_q <= 1'b0;
      serial_bit_q     <= 1'b0;
      serial_valid_q   <= 1'b0;
      pend_q           <= 1'b0;
      pend_bit_q       <= 1'b0;
      locked_q         <= 1'b0;
      slip_q           <= 1'b0;
    end else begin
      parallel_valid_q <= 1'b0;
      slip_q           <= 1'b0;
      if (pend_q) begin
        serial_bit_q   <= pend_bit_q;
        serial_valid_q <= 1'b1;
        pend_q         <= 1'b0;
      end else begin
        serial_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (sample_valid && sym_sync) begin
            cnt_q    <= CW'(1);
            locked_q <= 1'b1;
            state_q  <= INTEG;
          end
        end
        INTEG: begin
          if (sample_valid) begin
            if (sym_sync) begin
              cnt_q <= CW'(1);
              if (cnt_q != '0) slip_q <= 1'b1;
            end else if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= DECIDE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DECIDE: begin
          parallel_q[SYM_I_BIT] <= dec_i;
          parallel_q[SYM_Q_BIT] <= dec_q;
          parallel_valid_q      <= 1'b1;
          // A new decision overrides any bit still waiting in the serializer.
          serial_bit_q          <= dec_i;
          serial_valid_q        <= 1'b1;
          pend_q                <= 1'b1;
          pend_bit_q            <= dec_q;
          cnt_q                 <= sample_valid ? CW'(1) : '0;
          state_q               <= INTEG;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef QAM_DEMOD_SOFT_EN
  logic signed [AW-1:0] soft_i_q, soft_q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      soft_i_q <= '0;
      soft_q_q <= '0;
    end else if (state_q == DECIDE) begin
      soft_i_q <= acc_i;
      soft_q_q <= acc_q;
    end
  end

  assign soft_i = soft_i_q;
  assign soft_q = soft_q_q;
`endif

  assign parallel       = parallel_q;
  assign parallel_valid = parallel_valid_q;
  assign serial_bit     = serial_bit_q;
  assign serial_valid   = serial_valid_q;
  assign locked         = locked_q;
  assign slip           = slip_q;

endmodule
